bus_mux_reg: RTL and testbench

Parametrised, registered successor to the 32-bit 32:1 datapath bus multiplexer. It takes NSRC one-hot "Rxout"-style drive enables and NSRC WIDTH-bit source words, and drives a single registered datapath bus. On top of plain selection it adds an encoded-select readback, an idle hold/zero mode, a sticky multi-driver conflict detector with a capture register, and a saturating transfer counter. It sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and the CPU bus consumers.

---
 rtl/bus_mux_reg.sv | 105 ++++++++++
 tb/tb_bus_mux_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// Registered N:1 datapath bus multiplexer with priority select.
// Also provides encoded select, conflict capture and a transfer counter.
//
// Ports:
//   clk           system clock, rising edge
//   clr_n         asynchronous active-low reset
//   src_out       per-source drive enables, bit i = source i
//   src_data      flattened source words, source i at [i*WIDTH +: WIDTH]
//   err_clr       synchronous clear of conflict / conflict_mask
//   cnt_clr       synchronous clear of xfer_count
//   bus_out       registered bus value
//   bus_valid     high for the cycle after an enabled edge
//   bus_sel       index of the source that won the last transfer
//   conflict      sticky multi-driver flag
//   conflict_mask sticky OR of src_out over conflicting edges
//   xfer_count    saturating count of enabled edges
module bus_mux_reg #(
    parameter int   WIDTH     = 32,
    parameter int   NSRC      = 24,
    parameter bit   HOLD_IDLE = 1'b1,
    parameter int   CNTW      = 16,
    localparam int  SELW      = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [NSRC-1:0]       src_out,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  err_clr,
    input  logic                  cnt_clr,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [SELW-1:0]       bus_sel,
    output logic                  conflict,
    output logic [NSRC-1:0]       conflict_mask,
    output logic [CNTW-1:0]       xfer_count
);

    logic [SELW-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;
    logic             any_en;
    logic             multi_en;
    logic             cnt_sat;

    // Scan from the top down so the lowest set index is the last
    // assignment and therefore wins.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        any_en   = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                win_idx  = SELW'(i);
                win_data = src_data[i*WIDTH +: WIDTH];
                any_en   = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or
    // more enables are active.
    assign multi_en = |(src_out & (src_out - NSRC'(1)));
    assign cnt_sat  = &xfer_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            bus_sel   <= '0;
        end else begin
            bus_valid <= any_en;
            if (any_en) begin
                bus_out <= win_data;
                bus_sel <= win_idx;
            end else if (!HOLD_IDLE) begin
                bus_out <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            xfer_count <= '0;
        end else if (cnt_clr) begin
            xfer_count <= '0;
        end else if (any_en && !cnt_sat) begin
            xfer_count <= xfer_count + CNTW'(1);
        end
    end

    // A fresh conflict on the clearing edge survives the clear and
    // its mask restarts from this edge's enables only.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            conflict      <= 1'b0;
            conflict_mask <= '0;
        end else if (multi_en) begin
            conflict      <= 1'b1;
            conflict_mask <= (err_clr ? '0 : conflict_mask) | src_out;
        end else if (err_clr) begin
            conflict      <= 1'b0;
            conflict_mask <= '0;
        end
    end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Self-checking bench for bus_mux_reg: three instances with different
// parameters share one stimulus stream and one behavioural model.
module tb_bus_mux_reg;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic [31:0]   so = '0;
    logic [1023:0] sd = '0;
    logic [191:0]  sd2;
    logic          ec = 1'b0;
    logic          cc = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        sd2 = '0;
        for (int i = 0; i < 24; i++) sd2[i*8 +: 8] = sd[i*32 +: 8];
    end

    logic [31:0] b0, b1;
    logic [7:0]  b2;
    logic        v0, v1, v2;
    logic [4:0]  s0, s1, s2;
    logic        c0, c1, c2;
    logic [31:0] k0, k1;
    logic [23:0] k2;
    logic [15:0] n0, n2;
    logic [3:0]  n1;

    bus_mux_reg #(.WIDTH(32), .NSRC(32), .HOLD_IDLE(1'b1), .CNTW(16)) u0 (
        .clk(clk), .clr_n(clr_n), .src_out(so), .src_data(sd),
        .err_clr(ec), .cnt_clr(cc), .bus_out(b0), .bus_valid(v0),
        .bus_sel(s0), .conflict(c0), .conflict_mask(k0), .xfer_count(n0));

    bus_mux_reg #(.WIDTH(32), .NSRC(32), .HOLD_IDLE(1'b0), .CNTW(4)) u1 (
        .clk(clk), .clr_n(clr_n), .src_out(so), .src_data(sd),
        .err_clr(ec), .cnt_clr(cc), .bus_out(b1), .bus_valid(v1),
        .bus_sel(s1), .conflict(c1), .conflict_mask(k1), .xfer_count(n1));

    bus_mux_reg #(.WIDTH(8), .NSRC(24), .HOLD_IDLE(1'b1), .CNTW(16)) u2 (
        .clk(clk), .clr_n(clr_n), .src_out(so[23:0]), .src_data(sd2),
        .err_clr(ec), .cnt_clr(cc), .bus_out(b2), .bus_valid(v2),
        .bus_sel(s2), .conflict(c2), .conflict_mask(k2), .xfer_count(n2));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: per-instance parameters and architectural state.
    int          pn[3]   = '{32, 32, 24};
    int          pw[3]   = '{32, 32, 8};
    bit          ph[3]   = '{1'b1, 1'b0, 1'b1};
    int          pmax[3] = '{65535, 15, 65535};
    logic [63:0] m_bus[3]  = '{64'd0, 64'd0, 64'd0};
    bit          m_val[3]  = '{1'b0, 1'b0, 1'b0};
    int          m_sel[3]  = '{0, 0, 0};
    bit          m_conf[3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] m_mask[3] = '{64'd0, 64'd0, 64'd0};
    int          m_cnt[3]  = '{0, 0, 0};

    task automatic model_step(input int k);
        logic [63:0] en;
        logic [63:0] wm;
        int          win;
        en  = {32'd0, so} & ((64'd1 << pn[k]) - 64'd1);
        wm  = (64'd1 << pw[k]) - 64'd1;
        win = -1;
        for (int i = 0; i < pn[k]; i++)
            if (en[i] && win < 0) win = i;
        if (win >= 0) begin
            m_bus[k] = {32'd0, sd[win*32 +: 32]} & wm;
            m_sel[k] = win;
            m_val[k] = 1'b1;
            if (m_cnt[k] < pmax[k]) m_cnt[k]++;
        end else begin
            m_val[k] = 1'b0;
            if (!ph[k]) m_bus[k] = 64'd0;
        end
        if (cc) m_cnt[k] = 0;
        if ($countones(en) >= 2) begin
            m_conf[k] = 1'b1;
            m_mask[k] = (ec ? 64'd0 : m_mask[k]) | en;
        end else if (ec) begin
            m_conf[k] = 1'b0;
            m_mask[k] = 64'd0;
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!clr_n) begin
                m_bus[k]  = 64'd0;
                m_val[k]  = 1'b0;
                m_sel[k]  = 0;
                m_conf[k] = 1'b0;
                m_mask[k] = 64'd0;
                m_cnt[k]  = 0;
            end else begin
                model_step(k);
            end
        end
    end

    task automatic cmp_inst(input int k, input logic [63:0] bus,
                            input logic [63:0] val, input logic [63:0] sel,
                            input logic [63:0] cf, input logic [63:0] msk,
                            input logic [63:0] cnt);
        chk($sformatf("u%0d.bus_out", k), bus, m_bus[k]);
        chk($sformatf("u%0d.bus_valid", k), val, 64'(m_val[k]));
        chk($sformatf("u%0d.bus_sel", k), sel, 64'(m_sel[k]));
        chk($sformatf("u%0d.conflict", k), cf, 64'(m_conf[k]));
        chk($sformatf("u%0d.conflict_mask", k), msk, m_mask[k]);
        chk($sformatf("u%0d.xfer_count", k), cnt, 64'(m_cnt[k]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, 64'(b0), 64'(v0), 64'(s0), 64'(c0), 64'(k0), 64'(n0));
        cmp_inst(1, 64'(b1), 64'(v1), 64'(s1), 64'(c1), 64'(k1), 64'(n1));
        cmp_inst(2, 64'(b2), 64'(v2), 64'(s2), 64'(c2), 64'(k2), 64'(n2));
    end

    // Apply inputs just after an edge, then land 1 time unit past the
    // next edge so registered outputs can be read directly.
    task automatic cyc(input logic [31:0] s, input logic e = 1'b0,
                       input logic c = 1'b0);
        so = s;
        ec = e;
        cc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".u0"}, 64'({b0, v0, s0, c0, k0, n0}), 64'd0);
        chk({nm, ".u1"}, 64'({b1, v1, s1, c1, k1, n1}), 64'd0);
        chk({nm, ".u2"}, 64'({b2, v2, s2, c2, k2, n2}), 64'd0);
    endtask

    task automatic async_pulse(input string nm);
        #1 clr_n = 1'b0;
        #1 chk_zero(nm);
        #1 clr_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) sd[i*32 +: 32] = 32'd1 << i;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        clr_n = 1'b1;

        cyc(32'h10);
        cyc(32'h80);
        chk("pre_rst.bus", 64'(b0), 64'h80);
        async_pulse("midrun_rst");

        for (int i = 0; i < 32; i++) begin
            cyc(32'd1 << i);
            chk("sweep.bus", 64'(b0), 64'd1 << i);
            chk("sweep.sel", 64'(s0), 64'(i));
            chk("sweep.valid", 64'(v0), 64'd1);
        end
        chk("sweep.count", 64'(n0), 64'd32);
        chk("sat4.count", 64'(n1), 64'd15);

        cyc(32'h20);
        for (int j = 0; j < 3; j++) begin
            cyc(32'h0);
            chk("idle_hold.bus", 64'(b0), 64'h20);
            chk("idle_zero.bus", 64'(b1), 64'h0);
            chk("idle.valid", 64'({v0, v1}), 64'h0);
            chk("idle.count", 64'(n0), 64'd33);
        end

        cyc(32'h0002_0008);
        chk("conf.bus", 64'(b0), 64'h8);
        chk("conf.sel", 64'(s0), 64'd3);
        chk("conf.flag", 64'(c0), 64'd1);
        chk("conf.mask", 64'(k0), 64'h0002_0008);
        chk("conf.mask24", 64'(k2), 64'h02_0008);
        cyc(32'h200);
        chk("conf.sticky", 64'(c0), 64'd1);
        cyc(32'h0, 1'b1);
        chk("errclr", 64'({c0, k0}), 64'd0);
        cyc(32'h6, 1'b1);
        chk("errclr_new.flag", 64'(c0), 64'd1);
        chk("errclr_new.mask", 64'(k0), 64'h6);

        cyc(32'h1, 1'b0, 1'b1);
        chk("cntclr.u0", 64'(n0), 64'd0);
        chk("cntclr.u1", 64'(n1), 64'd0);
        for (int j = 0; j < 20; j++) cyc(32'd1 << (j % 32));
        chk("sat.u1", 64'(n1), 64'd15);
        chk("nosat.u0", 64'(n0), 64'd20);

        sd[23*32 +: 32] = 32'hA5;
        cyc(32'd1 << 23);
        chk("np2.sel", 64'(s2), 64'd23);
        chk("np2.bus", 64'(b2), 64'hA5);
        cyc(32'd1 << 30);
        chk("np2.absent_valid", 64'(v2), 64'd0);
        chk("np2.absent_sel", 64'(s2), 64'd23);
        chk("np2.u0sel", 64'(s0), 64'd30);
        async_pulse("np2_rst");
        cyc(32'h0);
        cyc(32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
